stack_cmd_frontend: RTL



---
 rtl/stack_cmd_frontend_if.sv | 21 ++
 rtl/stack_cmd_frontend.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stack_cmd_frontend_if.sv
// Command bus between stack_cmd_frontend (master) and dual_stack (slave).
interface stack_cmd_frontend_if;
  logic       push;
  logic       pop;
  logic       stack_select;
  logic [7:0] data_out;
  logic       s1_empty;
  logic       s1_full;
  logic       s2_empty;
  logic       s2_full;

  modport master (
    output push, pop, stack_select, data_out,
    input  s1_empty, s1_full, s2_empty, s2_full
  );

  modport slave (
    input  push, pop, stack_select, data_out,
    output s1_empty, s1_full, s2_empty, s2_full
  );
endinterface

// File: rtl/stack_cmd_frontend.sv
// stack_cmd_frontend: synchronises and debounces push/pop buttons, turns each
// debounced press into a single-cycle command for dual_stack and blocks
// overflow, underflow and push/pop conflicts with sticky error flags.
// Optional feature: define STACK_CMD_AUTO_REPEAT_EN for auto-repeat while held.
module stack_cmd_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_push,
  input  logic                 btn_pop,
  input  logic                 sel_in,
  input  logic [7:0]           data_in,
  stack_cmd_frontend_if.master bus,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_conflict
);

  // Elaboration-time parameter sanity checks
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if ((64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  // Index 0 = push button, index 1 = pop button
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic             sel_s1;
  logic             sel_s2;
  logic [1:0]       settle_cnt;
  logic [1:0]       arm;
  logic [1:0]       stable;
  logic [1:0]       stable_d;
  logic [CNT_W-1:0] db_cnt [2];
  logic [1:0]       req_c;
  logic             tgt_full_c;
  logic             tgt_empty_c;

  assign tgt_full_c  = sel_s2 ? bus.s2_full  : bus.s1_full;
  assign tgt_empty_c = sel_s2 ? bus.s2_empty : bus.s1_empty;

`ifdef STACK_CMD_AUTO_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);

  logic [REP_W-1:0] rep_cnt [2];
  logic [1:0]       rep_hit_c;

  // Repeat fires REPEAT_CYCLES cycles after the previous request while held
  always_comb begin
    rep_hit_c = '0;
    for (int i = 0; i < 2; i++) begin
      rep_hit_c[i] = stable[i] & stable_d[i] &
                     (rep_cnt[i] == REP_W'(REPEAT_CYCLES - 1));
    end
  end

  // Request = fresh press edge or repeat tick, only once the button is armed
  always_comb begin
    req_c = arm & ((stable & ~stable_d) | rep_hit_c);
  end

  // Repeat counters restart on each request, on release and on conflict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt[0] <= '0;
      rep_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!stable[i] || (req_c == 2'b11) || (stable[i] && !stable_d[i]) ||
            rep_hit_c[i]) begin
          rep_cnt[i] <= '0;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
        end
      end
    end
  end
`else
  // Request = fresh press edge, only once the button is armed
  always_comb begin
    req_c = arm & stable & ~stable_d;
  end
`endif

  // Synchronise, debounce, arm and issue the registered command decision.
  // A button is armed only after it is seen released once the synchronisers
  // have refilled after reset, so a press spanning reset never issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1            <= '0;
      sync2            <= '0;
      sel_s1           <= 1'b0;
      sel_s2           <= 1'b0;
      settle_cnt       <= '0;
      arm              <= '0;
      stable           <= '0;
      stable_d         <= '0;
      db_cnt[0]        <= '0;
      db_cnt[1]        <= '0;
      bus.push         <= 1'b0;
      bus.pop          <= 1'b0;
      bus.stack_select <= 1'b0;
      bus.data_out     <= 8'h00;
      err_overflow     <= 1'b0;
      err_underflow    <= 1'b0;
      err_conflict     <= 1'b0;
    end else begin
      sync1  <= {btn_pop, btn_push};
      sync2  <= sync1;
      sel_s1 <= sel_in;
      sel_s2 <= sel_s1;

      if (settle_cnt != 2'd2) begin
        settle_cnt <= settle_cnt + 2'd1;
      end

      for (int i = 0; i < 2; i++) begin
        if ((settle_cnt == 2'd2) && !sync2[i]) begin
          arm[i] <= 1'b1;
        end
        stable_d[i] <= stable[i];
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end

      bus.push <= 1'b0;
      bus.pop  <= 1'b0;
      case (req_c)
        2'b01: begin
          if (tgt_full_c) begin
            err_overflow <= 1'b1;
          end else begin
            bus.push         <= 1'b1;
            bus.stack_select <= sel_s2;
            bus.data_out     <= data_in;
          end
        end
        2'b10: begin
          if (tgt_empty_c) begin
            err_underflow <= 1'b1;
          end else begin
            bus.pop          <= 1'b1;
            bus.stack_select <= sel_s2;
          end
        end
        2'b11: begin
          err_conflict <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
